pe_mac_lane: RTL and testbench

- Parametrised next-generation PE datapath: PEROW parallel signed MAC rows with a 3-phase pipeline (operand fetch, multiply, accumulate).
- Supports full-width and dual packed half-width precision, configurable accumulation length and group count, and a saturating accumulator with sticky overflow.
- Sits between the PE-array input/weight distributors (rdy/ack in) and the psum collector (rdy/ack out).
- Works on streamed operands, with no internal pads.

---
 rtl/pe_mac_lane_pkg.sv | 37 +++
 rtl/pe_mac_row.sv | 83 ++++++++
 rtl/pe_mac_lane.sv | 162 ++++++++++++++++
 tb/tb_pe_mac_lane.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_lane_pkg.sv
// Shared types and constants for the PE MAC lane: configuration word, lane FSM states,
// default widths and saturation-limit helpers.
package PELaneCfg;

    localparam int LANE_DWD     = 8;
    localparam int LANE_PEROW   = 4;
    localparam int LANE_PSUMDWD = 24;
    // The configuration word layout depends on these, so they live here rather than per instance.
    localparam int MAXACC       = 64;
    localparam int MAXGRP       = 256;
    localparam int ACC_W        = $clog2(MAXACC + 1);
    localparam int GRP_W        = $clog2(MAXGRP + 1);

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_DUAL = 1'b1;

    typedef struct packed {
        logic             mode;
        logic [ACC_W-1:0] acc_len;
        logic [GRP_W-1:0] grp_num;
    } LaneConf;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } LaneState;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_mac_row.sv
// One MAC row: full or dual packed product, stage-1 product register and
// saturating accumulator with a sticky overflow flag.
module pe_mac_row
    import PELaneCfg::*;
#(
    parameter int DWD     = LANE_DWD,
    parameter int PSUMDWD = LANE_PSUMDWD
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic                      i_load,
    input  logic [DWD-1:0]            i_in,
    input  logic [DWD-1:0]            i_w,
    input  logic                      i_acc_en,
    input  logic                      i_first,
    output logic signed [PSUMDWD-1:0] o_acc_next,
    output logic                      o_ovf_next
);

    localparam int HW = DWD / 2;
    localparam int PW = 2 * DWD;
    localparam int SW = PSUMDWD + 1;
    localparam logic signed [PSUMDWD-1:0] SAT_MAX = PSUMDWD'(sat_max(PSUMDWD));
    localparam logic signed [PSUMDWD-1:0] SAT_MIN = PSUMDWD'(sat_min(PSUMDWD));

    logic signed [DWD-1:0]     in_s, w_s;
    logic signed [HW-1:0]      in_hi, in_lo, w_hi, w_lo;
    logic signed [PW-1:0]      prod_d, prod_q;
    logic signed [PSUMDWD-1:0] acc_d, acc_q;
    logic                      ovf_d, ovf_q;
    logic signed [PSUMDWD-1:0] base;
    logic signed [SW-1:0]      sum;
    logic                      sat_hit;

    always_comb begin
        in_s  = $signed(i_in);
        w_s   = $signed(i_w);
        in_hi = $signed(i_in[DWD-1:HW]);
        in_lo = $signed(i_in[HW-1:0]);
        w_hi  = $signed(i_w[DWD-1:HW]);
        w_lo  = $signed(i_w[HW-1:0]);
        prod_d = prod_q;
        if (i_load) begin
            if (i_mode == MODE_DUAL) begin
                prod_d = PW'(in_hi) * PW'(w_hi) + PW'(in_lo) * PW'(w_lo);
            end else begin
                prod_d = PW'(in_s) * PW'(w_s);
            end
        end
    end

    // One extra bit of headroom is enough: |prod| is always below 2^(PSUMDWD-1).
    always_comb begin
        base       = i_first ? '0 : acc_q;
        sum        = SW'(base) + SW'(prod_q);
        sat_hit    = 1'b0;
        o_acc_next = sum[PSUMDWD-1:0];
        if (sum > SW'(SAT_MAX)) begin
            o_acc_next = SAT_MAX;
            sat_hit    = 1'b1;
        end else if (sum < SW'(SAT_MIN)) begin
            o_acc_next = SAT_MIN;
            sat_hit    = 1'b1;
        end
        o_ovf_next = (i_first ? 1'b0 : ovf_q) | sat_hit;
        acc_d      = i_acc_en ? o_acc_next : acc_q;
        ovf_d      = i_acc_en ? o_ovf_next : ovf_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/pe_mac_lane.sv
// PE MAC lane: PEROW parallel MAC rows behind a joined input/weight handshake,
// group/beat sequencing FSM and a backpressured result register.
module pe_mac_lane
    import PELaneCfg::*;
#(
    parameter int DWD     = LANE_DWD,
    parameter int PEROW   = LANE_PEROW,
    parameter int PSUMDWD = LANE_PSUMDWD
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_conf_valid,
    input  LaneConf                         i_conf,
    output logic                            o_busy,
    input  logic                            Input_rdy,
    output logic                            Input_ack,
    input  logic [PEROW-1:0][DWD-1:0]       i_Input,
    input  logic                            Weight_rdy,
    output logic                            Weight_ack,
    input  logic [PEROW-1:0][DWD-1:0]       i_Weight,
    output logic                            Psum_rdy,
    input  logic                            Psum_ack,
    output logic [PEROW-1:0][PSUMDWD-1:0]   o_Psum,
    output logic [PEROW-1:0]                o_ovf
);

    LaneState                       state_d, state_q;
    LaneConf                        conf_d, conf_q;
    logic [ACC_W-1:0]               beat_cnt_d, beat_cnt_q;
    logic [GRP_W-1:0]               grp_cnt_d, grp_cnt_q;
    logic                           s1_valid_d, s1_valid_q;
    logic                           s1_first_d, s1_first_q;
    logic                           s1_last_d, s1_last_q;
    logic                           psum_rdy_d, psum_rdy_q;
    logic [PEROW-1:0][PSUMDWD-1:0]  psum_d, psum_q;
    logic [PEROW-1:0]               ovf_d, ovf_q;

    logic [PEROW-1:0][PSUMDWD-1:0]  row_acc;
    logic [PEROW-1:0]               row_ovf;
    logic                           stall, take, acc_en, load_out;
    logic                           first_tag, last_tag, last_grp;

    // Only a finishing group can block: it needs the output register, a partial sum does not.
    assign stall     = s1_valid_q & s1_last_q & psum_rdy_q & ~Psum_ack;
    assign take      = (state_q == RUN) & Input_rdy & Weight_rdy & ~stall;
    assign acc_en    = s1_valid_q & ~stall;
    assign load_out  = s1_valid_q & s1_last_q & ~stall;
    assign first_tag = (beat_cnt_q == '0);
    assign last_tag  = (beat_cnt_q == conf_q.acc_len - ACC_W'(1));
    assign last_grp  = (grp_cnt_q == conf_q.grp_num - GRP_W'(1));

    assign Input_ack  = take;
    assign Weight_ack = take;
    assign Psum_rdy   = psum_rdy_q;
    assign o_Psum     = psum_q;
    assign o_ovf      = ovf_q;
    assign o_busy     = (state_q != IDLE) | s1_valid_q | psum_rdy_q;

    generate
        for (genvar gi = 0; gi < PEROW; gi++) begin : g_row
            pe_mac_row #(
                .DWD     (DWD),
                .PSUMDWD (PSUMDWD)
            ) u_row (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_mode     (conf_q.mode),
                .i_load     (take),
                .i_in       (i_Input[gi]),
                .i_w        (i_Weight[gi]),
                .i_acc_en   (acc_en),
                .i_first    (s1_first_q),
                .o_acc_next (row_acc[gi]),
                .o_ovf_next (row_ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        conf_d     = conf_q;
        beat_cnt_d = beat_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_conf_valid && (i_conf.acc_len != '0) && (i_conf.grp_num != '0)) begin
                    conf_d     = i_conf;
                    beat_cnt_d = '0;
                    grp_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (take) begin
                    if (last_tag) begin
                        beat_cnt_d = '0;
                        grp_cnt_d  = grp_cnt_q + GRP_W'(1);
                        if (last_grp) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + ACC_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid_q && !psum_rdy_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (!stall) begin
            s1_valid_d = take;
            s1_first_d = first_tag;
            s1_last_d  = last_tag;
        end
        psum_rdy_d = psum_rdy_q;
        psum_d     = psum_q;
        ovf_d      = ovf_q;
        if (load_out) begin
            psum_rdy_d = 1'b1;
            psum_d     = row_acc;
            ovf_d      = row_ovf;
        end else if (Psum_ack) begin
            psum_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            conf_q     <= '0;
            beat_cnt_q <= '0;
            grp_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            psum_rdy_q <= 1'b0;
            psum_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            conf_q     <= conf_d;
            beat_cnt_q <= beat_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            psum_rdy_q <= psum_rdy_d;
            psum_q     <= psum_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pe_mac_lane.sv
// Bench for pe_mac_lane: a 24-bit and a 16-bit accumulator lane share stimulus;
// a scoreboard model predicts every result of both.
module tb_pe_mac_lane;
    import PELaneCfg::*;

    typedef logic [3:0][7:0] vec_t;
    typedef struct packed {
        logic [3:0][23:0] p24;
        logic [3:0]       o24;
        logic [3:0][15:0] p16;
        logic [3:0]       o16;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst, conf_valid, in_rdy, w_rdy, psum_ack;
    LaneConf conf;
    vec_t    in_vec, w_vec;
    logic    busy, in_ack, w_ack, psum_rdy;
    logic    busy16, in_ack16, w_ack16, psum_rdy16;
    logic [3:0][23:0] psum;
    logic [3:0][15:0] psum16;
    logic [3:0]       ovf, ovf16;

    pe_mac_lane #(.DWD(8), .PEROW(4), .PSUMDWD(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_conf_valid(conf_valid), .i_conf(conf), .o_busy(busy),
        .Input_rdy(in_rdy), .Input_ack(in_ack), .i_Input(in_vec),
        .Weight_rdy(w_rdy), .Weight_ack(w_ack), .i_Weight(w_vec),
        .Psum_rdy(psum_rdy), .Psum_ack(psum_ack), .o_Psum(psum), .o_ovf(ovf)
    );

    pe_mac_lane #(.DWD(8), .PEROW(4), .PSUMDWD(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_conf_valid(conf_valid), .i_conf(conf), .o_busy(busy16),
        .Input_rdy(in_rdy), .Input_ack(in_ack16), .i_Input(in_vec),
        .Weight_rdy(w_rdy), .Weight_ack(w_ack16), .i_Weight(w_vec),
        .Psum_rdy(psum_rdy16), .Psum_ack(psum_ack), .o_Psum(psum16), .o_ovf(ovf16)
    );

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    res_t log_q[$];

    int     m_acc_len = 1;
    logic   m_mode = 1'b0;
    int     m_beat = 0;
    longint m_acc24 [4];
    longint m_acc16 [4];
    bit     m_ovf24 [4];
    bit     m_ovf16 [4];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint prod_of(input logic mode, input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa, sw;
        logic signed [3:0] ah, al, bh, bl;
        sa = a; sw = b;
        ah = a[7:4]; al = a[3:0]; bh = b[7:4]; bl = b[3:0];
        if (mode) return longint'(ah) * longint'(bh) + longint'(al) * longint'(bl);
        return longint'(sa) * longint'(sw);
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint hi, lo;
        lo = -(longint'(1) <<< (w - 1));
        hi = -lo - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        longint p, s, c;
        bit     first;
        res_t   e, got;
        if (!rst) begin
            if (in_ack) begin
                check("weight_ack_join", longint'(w_ack), 1);
                check("both_rdy_on_ack", longint'(in_rdy & w_rdy), 1);
                check("ack16_agrees", longint'(in_ack16 & w_ack16), 1);
                first = (m_beat == 0);
                for (int r = 0; r < 4; r++) begin
                    p = prod_of(m_mode, in_vec[r], w_vec[r]);
                    s = (first ? 0 : m_acc24[r]) + p;
                    c = clamp(s, 24);
                    m_ovf24[r] = (first ? 1'b0 : m_ovf24[r]) | (c != s);
                    m_acc24[r] = c;
                    s = (first ? 0 : m_acc16[r]) + p;
                    c = clamp(s, 16);
                    m_ovf16[r] = (first ? 1'b0 : m_ovf16[r]) | (c != s);
                    m_acc16[r] = c;
                end
                if (m_beat == m_acc_len - 1) begin
                    for (int r = 0; r < 4; r++) begin
                        e.p24[r] = 24'(m_acc24[r]);
                        e.o24[r] = m_ovf24[r];
                        e.p16[r] = 16'(m_acc16[r]);
                        e.o16[r] = m_ovf16[r];
                    end
                    sb.push_back(e);
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (psum_rdy && psum_ack) begin
                got.p24 = psum; got.o24 = ovf; got.p16 = psum16; got.o16 = ovf16;
                log_q.push_back(got);
                check("rdy16_agrees", longint'(psum_rdy16), 1);
                check("scoreboard_nonempty", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int r = 0; r < 4; r++) begin
                        check($sformatf("psum24[%0d]", r), longint'($signed(psum[r])), longint'($signed(e.p24[r])));
                        check($sformatf("ovf24[%0d]", r), longint'(ovf[r]), longint'(e.o24[r]));
                        check($sformatf("psum16[%0d]", r), longint'($signed(psum16[r])), longint'($signed(e.p16[r])));
                        check($sformatf("ovf16[%0d]", r), longint'(ovf16[r]), longint'(e.o16[r]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_conf(input logic mode, input int acc, input int grp, input bit accept);
        conf_valid   = 1'b1;
        conf.mode    = mode;
        conf.acc_len = ACC_W'(acc);
        conf.grp_num = GRP_W'(grp);
        if (accept) begin
            m_mode = mode; m_acc_len = acc; m_beat = 0;
        end
        tick();
        conf_valid = 1'b0;
    endtask

    task automatic send_beat(input vec_t iv, input vec_t wv);
        bit seen;
        seen = 1'b0;
        in_vec = iv; w_vec = wv; in_rdy = 1'b1; w_rdy = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("beat_accepted", longint'(seen), 1);
        tick();
        in_rdy = 1'b0; w_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy && !busy16) break;
        end
        check("reached_idle", longint'(busy | busy16), 0);
        tick();
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int r = 0; r < 4; r++) v[r] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [7:0] x);
        vec_t v;
        for (int r = 0; r < 4; r++) v[r] = x;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        vec_t iv, wv;
        vec_t iv3 [3];
        vec_t wv3 [3];
        int   n0, k, nacks;
        bit   a, have_first;
        logic [3:0][23:0] first_val;

        rst = 1'b1; conf_valid = 1'b0; conf = '0; in_rdy = 1'b0; w_rdy = 1'b0;
        psum_ack = 1'b0; in_vec = '0; w_vec = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_psum_rdy", longint'(psum_rdy), 0);
        check("reset_psum0", longint'(psum[0]), 0);
        check("reset_ovf", longint'(ovf), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_ack", longint'(in_ack | w_ack), 0);
        tick();

        // 1: full mode, 3-beat group, exact result latency
        psum_ack = 1'b1;
        send_conf(1'b0, 3, 1, 1'b1);
        iv = rand_vec(); wv = rand_vec(); iv[0] = 8'd2; wv[0] = 8'd3;
        send_beat(iv, wv);
        iv = rand_vec(); wv = rand_vec(); iv[0] = 8'hFC; wv[0] = 8'd5;
        send_beat(iv, wv);
        iv = rand_vec(); wv = rand_vec(); iv[0] = 8'd7; wv[0] = 8'hFF;
        send_beat(iv, wv);
        @(negedge clk);
        check("t1_rdy_at_t1", longint'(psum_rdy), 0);
        @(negedge clk);
        check("t1_rdy_at_t2", longint'(psum_rdy), 1);
        check("t1_psum0", longint'($signed(psum[0])), -21);
        wait_idle();

        // 2: dual packed mode
        send_conf(1'b1, 1, 1, 1'b1);
        n0 = log_q.size();
        iv = rand_vec(); wv = rand_vec();
        iv[0] = 8'h12; wv[0] = 8'h3F; iv[1] = 8'h88; wv[1] = 8'h88;
        send_beat(iv, wv);
        wait_idle();
        check("t2_count", log_q.size(), n0 + 1);
        if (log_q.size() > n0) begin
            check("t2_row0", longint'($signed(log_q[n0].p24[0])), 1);
            check("t2_row1", longint'($signed(log_q[n0].p24[1])), 128);
        end
        send_conf(1'b1, 3, 2, 1'b1);
        for (int b = 0; b < 6; b++) send_beat(rand_vec(), rand_vec());
        wait_idle();

        // 3: backpressure with rdys held high
        send_conf(1'b0, 1, 3, 1'b1);
        n0 = log_q.size();
        psum_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin iv3[b] = rand_vec(); wv3[b] = rand_vec(); end
        k = 0; nacks = 0; have_first = 1'b0; first_val = '0;
        in_vec = iv3[0]; w_vec = wv3[0]; in_rdy = 1'b1; w_rdy = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
            if (cyc == 6) begin
                check("t3_acks_while_stalled", nacks, 2);
                psum_ack = 1'b1;
            end
            @(negedge clk);
            a = in_ack;
            if (a) nacks++;
            if (cyc < 6 && psum_rdy) begin
                if (!have_first) begin
                    first_val = psum; have_first = 1'b1;
                end else begin
                    check("t3_result_stable", longint'(psum == first_val), 1);
                end
            end
            tick();
            if (a) begin
                k++;
                if (k < 3) begin in_vec = iv3[k]; w_vec = wv3[k]; end
                else begin in_rdy = 1'b0; w_rdy = 1'b0; end
            end
        end
        in_rdy = 1'b0; w_rdy = 1'b0;
        check("t3_all_beats_taken", k, 3);
        wait_idle();
        check("t3_count", log_q.size(), n0 + 3);

        // 4: saturation on the 16-bit lane, sticky ovf cleared per group
        send_conf(1'b0, 4, 3, 1'b1);
        n0 = log_q.size();
        for (int b = 0; b < 4; b++) send_beat(fill_vec(8'd127), fill_vec(8'd127));
        for (int b = 0; b < 4; b++) send_beat(fill_vec(8'd127), fill_vec(8'd1));
        for (int b = 0; b < 4; b++) send_beat(fill_vec(8'h80), fill_vec(8'd127));
        wait_idle();
        check("t4_count", log_q.size(), n0 + 3);
        if (log_q.size() >= n0 + 3) begin
            check("t4_sat_pos16", longint'($signed(log_q[n0].p16[0])), 32767);
            check("t4_ovf_pos16", longint'(log_q[n0].o16[0]), 1);
            check("t4_nosat24", longint'($signed(log_q[n0].p24[0])), 64516);
            check("t4_noovf24", longint'(log_q[n0].o24[0]), 0);
            check("t4_next16", longint'($signed(log_q[n0+1].p16[0])), 508);
            check("t4_next_ovf16", longint'(log_q[n0+1].o16[0]), 0);
            check("t4_sat_neg16", longint'($signed(log_q[n0+2].p16[3])), -32768);
            check("t4_ovf_neg16", longint'(log_q[n0+2].o16[3]), 1);
        end

        // 5: configuration filtering and join handshake
        send_conf(1'b0, 0, 2, 1'b0);
        send_conf(1'b0, 2, 0, 1'b0);
        in_rdy = 1'b1; w_rdy = 1'b1;
        @(negedge clk);
        check("t5_zero_conf_busy", longint'(busy), 0);
        check("t5_idle_no_ack", longint'(in_ack), 0);
        tick();
        in_rdy = 1'b0; w_rdy = 1'b0;
        send_conf(1'b0, 2, 2, 1'b1);
        @(negedge clk);
        check("t5_run_busy", longint'(busy), 1);
        tick();
        send_conf(1'b0, 1, 1, 1'b0);
        in_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_input_only_no_ack", longint'(in_ack | w_ack), 0);
        end
        tick();
        in_rdy = 1'b0;
        n0 = log_q.size();
        for (int b = 0; b < 4; b++) send_beat(rand_vec(), rand_vec());
        wait_idle();
        check("t5_count", log_q.size(), n0 + 2);

        // 6: reset mid-group with a pending result
        send_conf(1'b0, 4, 2, 1'b1);
        psum_ack = 1'b0;
        for (int b = 0; b < 6; b++) send_beat(rand_vec(), rand_vec());
        @(negedge clk);
        check("t6_pending", longint'(psum_rdy), 1);
        rst = 1'b1;
        sb.delete();
        m_beat = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_rdy", longint'(psum_rdy), 0);
        check("t6_rst_psum0", longint'(psum[0]), 0);
        check("t6_rst_busy", longint'(busy), 0);
        tick();
        psum_ack = 1'b1;
        send_conf(1'b0, 2, 1, 1'b1);
        n0 = log_q.size();
        send_beat(fill_vec(8'd1), fill_vec(8'd1));
        send_beat(fill_vec(8'd1), fill_vec(8'd1));
        wait_idle();
        check("t6_count", log_q.size(), n0 + 1);
        if (log_q.size() > n0) begin
            check("t6_fresh24", longint'($signed(log_q[n0].p24[0])), 2);
            check("t6_fresh16", longint'($signed(log_q[n0].p16[2])), 2);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
